// File: rtl/preg_freelist_if.sv
// Rename-stage free-list bus: freed-preg returns in, free-queue write port and status out.
interface preg_freelist_if #(
    parameter int unsigned PREG_W = 7,
    parameter int unsigned CNT_W  = 8
);
    logic              sq_valid;
    logic [PREG_W-1:0] sq_preg;
    logic              sq_ready;
    logic              cm_valid;
    logic [PREG_W-1:0] cm_preg;
    logic              cm_ready;
    logic              fpq_full;
    logic              fpq_r_en;
    logic              fpq_w_en;
    logic [PREG_W-1:0] preg_in;
    logic              init_done;
    logic              rename_stall;
    logic [CNT_W-1:0]  free_count;

    modport master (
        output sq_valid, sq_preg, cm_valid, cm_preg, fpq_full, fpq_r_en,
        input  sq_ready, cm_ready, fpq_w_en, preg_in, init_done, rename_stall, free_count
    );

    modport slave (
        input  sq_valid, sq_preg, cm_valid, cm_preg, fpq_full, fpq_r_en,
        output sq_ready, cm_ready, fpq_w_en, preg_in, init_done, rename_stall, free_count
    );
endinterface

// File: rtl/preg_freelist_ctrl.sv
// Free physical-register queue controller: seeds the queue after reset, then arbitrates
// squash/commit preg returns into its single write port and tracks the free count.
module preg_freelist_ctrl #(
    parameter int unsigned NUM_AREGS    = 32,
    parameter int unsigned NUM_PREGS    = 128,
    parameter int unsigned QUEUE_DEPTH  = 96,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst,
    preg_freelist_if.slave  bus
);
    localparam int unsigned PregW = $clog2(NUM_PREGS);
    localparam int unsigned CntW  = $clog2(NUM_PREGS + 1);
    localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StInitFill, StRun} state_e;

    state_e           state_q;
    logic [PregW-1:0] fill_ptr_q;
    logic [CntW-1:0]  free_count_q;
    logic [StW-1:0]   starve_q;

    logic run, fill_wr, starved, grant_sq, grant_cm, dec;

    assign run      = (state_q == StRun) && !rst;
    assign fill_wr  = (state_q == StInitFill) && !rst;
    assign starved  = (starve_q == StW'(STARVE_LIMIT));

    // Commit only beats squash once it has lost STARVE_LIMIT times in a row.
    assign grant_cm = run && !bus.fpq_full && bus.cm_valid && (starved || !bus.sq_valid);
    assign grant_sq = run && !bus.fpq_full && bus.sq_valid && !grant_cm;

    assign bus.sq_ready = grant_sq;
    assign bus.cm_ready = grant_cm;
    assign bus.preg_in  = fill_wr  ? fill_ptr_q  :
                          grant_cm ? bus.cm_preg : bus.sq_preg;
    // x0 is hardwired, so a returned preg 0 is accepted but dropped.
    assign bus.fpq_w_en = fill_wr
                        || (grant_cm && (bus.cm_preg != '0))
                        || (grant_sq && (bus.sq_preg != '0));

    assign bus.init_done    = (state_q == StRun);
    assign bus.rename_stall = (state_q != StRun);
    assign bus.free_count   = free_count_q;

    assign dec = bus.fpq_r_en && (free_count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInitFill;
            fill_ptr_q   <= PregW'(NUM_AREGS);
            free_count_q <= '0;
            starve_q     <= '0;
        end else begin
            if (bus.fpq_w_en && !dec) begin
                if (free_count_q != CntW'(QUEUE_DEPTH)) free_count_q <= free_count_q + CntW'(1);
            end else if (dec && !bus.fpq_w_en) begin
                free_count_q <= free_count_q - CntW'(1);
            end

            if (state_q == StInitFill) begin
                fill_ptr_q <= fill_ptr_q + PregW'(1);
                if (fill_ptr_q == PregW'(NUM_PREGS - 1)) state_q <= StRun;
            end else begin
                if (grant_cm || !bus.cm_valid) begin
                    starve_q <= '0;
                end else if (grant_sq && !starved) begin
                    starve_q <= starve_q + StW'(1);
                end
            end
        end
    end
endmodule

// File: doc/preg_freelist_ctrl.md
Name: preg_freelist_ctrl

Overview:
- Controller for the free physical-register queue in the rename stage; owns the queue's single write port (fpq_w_en/preg_in).
- After reset it seeds the queue with pregs NUM_AREGS..NUM_PREGS-1, one per cycle, and stalls rename until seeding is done.
- In run mode it arbitrates freed-preg returns from the squash path and the commit path into the queue.
- Tracks the live free-register count from queue writes and rename reads.

Parameters:
- NUM_AREGS, 32, architectural registers; the RAT maps areg i to preg i at reset.
- NUM_PREGS, 128, physical registers; preg width is $clog2(NUM_PREGS) = 7.
- QUEUE_DEPTH, 96, free queue capacity (NUM_PREGS-NUM_AREGS).
- STARVE_LIMIT, 4, consecutive commit losses before commit is forced priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sq_valid  in  1  squash path returning a preg
- sq_preg  in  7  preg from squash path
- sq_ready  out  1  squash return accepted this cycle
- cm_valid  in  1  commit path returning an old alias
- cm_preg  in  7  preg from commit path
- cm_ready  out  1  commit return accepted this cycle
- fpq_full  in  1  free queue full
- fpq_r_en  in  1  rename popped a preg this cycle (the same strobe as the queue r_en)
- fpq_w_en  out  1  free queue write enable
- preg_in  out  7  free queue write data
- init_done  out  1  seeding complete
- rename_stall  out  1  hold rename (high while seeding)
- free_count  out  8  pregs currently in queue

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - state=INIT_FILL, fill_ptr=NUM_AREGS, free_count=0, starve_cnt=0.
  - init_done=0, rename_stall=1.
  - fpq_w_en=0, sq_ready=0, cm_ready=0.
- Reset asserted mid-run or mid-fill restarts seeding from NUM_AREGS. The queue shares rst, so the two stay consistent.
- INIT_FILL state:
  - Each cycle after reset deasserts: fpq_w_en=1, preg_in=fill_ptr, fill_ptr++.
  - sq_ready=cm_ready=0; requesters must hold their data.
  - On the write of NUM_PREGS-1, go to RUN next cycle. Seeding takes exactly 96 cycles.
  - init_done=1 and rename_stall=0 from the first RUN cycle.
- RUN state, arbitration (combinational ready/write; state registered):
  - No grant if fpq_full=1.
  - Default priority: squash over commit.
  - If starve_cnt==STARVE_LIMIT and cm_valid, commit wins over squash.
  - Grant X: X_ready=1, fpq_w_en=1, preg_in=X_preg. Transfer happens on valid&&ready.
  - At most one grant per cycle.
  - A loser must hold valid and data stable until it is granted.
- Starvation counter:
  - starve_cnt++ (saturating at STARVE_LIMIT) when cm_valid=1 and commit is not granted because squash won.
  - Cleared on a commit grant, or when cm_valid=0.
  - Not incremented while fpq_full=1.
- Preg 0: a return of preg 0 is handshaken (ready=1) but not written (fpq_w_en=0). x0 is never freed.
  - A preg-0 grant still counts as a commit grant for starve_cnt.
- free_count:
  - +1 on each fpq_w_en, -1 on each fpq_r_en; unchanged when both occur in one cycle.
  - fpq_r_en is ignored (no decrement) when free_count==0.
  - Saturates at QUEUE_DEPTH.
- fpq_r_en during INIT_FILL: rename is stalled, so none is expected. If it occurs, decrement per the rule above.

Test Plan:
- Reset, then idle: preg_in steps 32,33,…,127 with fpq_w_en=1 for 96 cycles; init_done rises the next cycle; free_count=96; rename_stall=0.
- Seeding at fill_ptr=60, then cm_valid with cm_preg=5 held: cm_ready=0 throughout seeding. After init_done it is written, but the queue is full, so the bench pulses fpq_r_en once first. Then cm_ready=1, preg_in=5, free_count=96.
- RUN with free_count=90: sq_valid(sq_preg=40) and cm_valid(cm_preg=41) both held, squash re-presenting a new preg each cycle. Squash is granted 4 consecutive cycles; on the 5th, commit is granted with preg_in=41 and starve_cnt resets.
- fpq_full=1 with both requesters valid: sq_ready=cm_ready=fpq_w_en=0, starve_cnt frozen. Drop full: squash is granted that cycle.
- cm_valid with cm_preg=0: cm_ready=1, fpq_w_en=0, free_count unchanged.
- Same-cycle write and fpq_r_en at free_count=50: stays 50. Assert rst mid-RUN: all outputs return to reset values, and seeding restarts at preg 32.
